led_display_phy: RTL and testbench
==================================

# led_display_phy

Row-serialising physical driver for a 64×32 HUB75-style RGB LED panel. It accepts one double-row (top half and bottom half pixels) per valid/ready handshake from the frame-RAM controller. It shifts the row out over six serial colour lines with a generated bit clock, then drives the row address and pulses the latch. It sits between the RAM controller and the panel pins.

## Interface
- SYS_CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BCLK_FREQ, 21_000_000: target bit-clock frequency in Hz.
- NUM_COLS, 64: pixels per row.
- NUM_ROWS, 32: panel rows; ADDR_W = log2(NUM_ROWS/2) = 4.
- Derived HALF = max(1, SYS_CLK_FREQ / (2·BCLK_FREQ)) uses integer division; HALF = 2 at the defaults.

Ports:
- clk_in  in  1  system clock; the block uses one clock.
- n_reset_in  in  1  reset, synchronous and active-low.
- row_in  in  6·NUM_COLS  row pixels in slices [k·NUM_COLS +: NUM_COLS]. k=0 red_top, 1 green_top, 2 blue_top, 3 red_bot, 4 green_bot, 5 blue_bot. Bit c is column c.
- row_valid_in  in  1  row_in and row_address_in are valid.
- row_ready_out  out  1  block can accept a row.
- row_address_in  in  ADDR_W  double-row address of row_in.
- latch_out  out  1  panel latch enable.
- red_top_out, green_top_out, blue_top_out  out  1 each  serial top-half colour.
- red_bot_out, green_bot_out, blue_bot_out  out  1 each  serial bottom-half colour.
- bit_clk_out  out  1  panel shift clock.
- address_out  out  ADDR_W  panel row address.

## Operation
- All outputs are registered.
- Reset values: row_ready_out=0, latch_out=0, all colour outputs=0, bit_clk_out=0, address_out=0, state=IDLE.
- IDLE state:
  - row_ready_out=1; colour outputs and bit_clk_out=0.
  - On row_valid_in && row_ready_out: capture row_in and row_address_in, drop ready, go to SHIFT.
- SHIFT state:
  - Columns are sent in order c = 0 … NUM_COLS-1.
  - Each bit lasts 2·HALF cycles: bit_clk_out low for HALF cycles, then high for HALF cycles.
  - The six colour outputs present column c for the whole bit period. They change only when bit_clk_out is low.
  - The panel samples on the rising bit_clk_out edge.
  - After the high phase of column NUM_COLS-1, go to LATCH.
- LATCH state:
  - bit_clk_out=0; colour outputs=0; address_out takes the captured address.
  - latch_out=1 for 2·HALF cycles, then go to IDLE.
- address_out holds its value between latches.
- row_valid_in is ignored while row_ready_out=0.
- Changes to row_in after acceptance have no effect.
- Address is unrestricted; all 2^ADDR_W values pass through unchanged.

## Timing
- The accept edge is at cycle T. At T+1: row_ready_out=0, column 0 is on the colour lines, bit_clk_out=0.
- The first bit_clk_out rise is at T+1+HALF.
- SHIFT covers cycles T+1 … T+2·HALF·NUM_COLS, which is 256 cycles at the defaults.
- LATCH covers the next 2·HALF cycles. At the defaults latch_out=1 during T+257…T+260, and address_out updates at T+257.
- row_ready_out=1 again at T+2·HALF·(NUM_COLS+1)+1, which is T+261 at the defaults.
- Back-to-back rows: a new accept can occur on the first ready cycle.
- Exactly NUM_COLS rising bit_clk_out edges and one latch pulse occur per accepted row.
- row_ready_out is 0 in the cycle after n_reset_in is sampled high, and 1 from the following cycle.
- Reset asserted at any point, including mid-SHIFT or mid-LATCH, aborts the transfer. All outputs take their reset values on the next clock edge. No partial latch pulse continues.

## Test plan
- Reset sequence: hold n_reset_in=0 for 10 cycles, then release.
  - During reset: all outputs 0.
  - After release: row_ready_out=1 two cycles later; no bit_clk_out activity.
- Single row: row_in with red_top=64'h0000_0000_0000_0001, blue_bot=64'h8000_0000_0000_0000, others 0, address 4'h5.
  - Exactly 64 bit_clk_out rises.
  - red_top_out=1 only at rise 1; blue_bot_out=1 only at rise 64.
  - address_out=5; latch_out high for 4 cycles; ready returns at T+261.
- Pattern check: green_top=64'hAAAA_AAAA_AAAA_AAAA.
  - Sampled green_top_out alternates 0,1,0,1… on rising edges.
  - Colour lines never change while bit_clk_out=1.
- Back-to-back: hold valid high for rows with addresses 0..15.
  - 16 latch pulses; address_out steps 0→15.
  - Each new accept happens on the first ready cycle; no extra bit clocks between rows.
- Valid while busy: toggle row_valid_in and change row_in during SHIFT.
  - Shifted data equals the captured row; no extra accept occurs.
- Mid-transfer reset: assert n_reset_in=0 at T+100.
  - At the next edge all outputs are 0 and no latch pulse occurs.
  - After release the next row transfers normally.

Source files
------------

// File: rtl/led_display_phy.sv
// led_display_phy: serialises one HUB75 double-row onto six colour lines with a
// generated bit clock, then drives the row address and pulses the latch.
// Latency: column 0 is on the pins the cycle after accept; a row occupies
//   2*HALF*(NUM_COLS+1) cycles from accept until ready returns.
// Backpressure: row_ready_out is low from accept until the latch pulse ends;
//   row_valid_in is ignored while it is low.
//
// Ports:
//   clk_in, n_reset_in          single clock, synchronous active-low reset
//   row_in / row_address_in     six NUM_COLS-bit colour slices + double-row address
//   row_valid_in / row_ready_out  valid/ready handshake with the frame-RAM side
//   *_top_out / *_bot_out       serial colour data, one bit per column
//   bit_clk_out                 panel shift clock (panel samples on rising edge)
//   latch_out / address_out     panel latch enable and row address
module led_display_phy #(
  parameter int SYS_CLK_FREQ = 100_000_000,
  parameter int BCLK_FREQ    = 21_000_000,
  parameter int NUM_COLS     = 64,
  parameter int NUM_ROWS     = 32,
  localparam int ADDR_W      = $clog2(NUM_ROWS / 2)
) (
  input  logic                  clk_in,
  input  logic                  n_reset_in,
  input  logic [6*NUM_COLS-1:0] row_in,
  input  logic                  row_valid_in,
  output logic                  row_ready_out,
  input  logic [ADDR_W-1:0]     row_address_in,
  output logic                  latch_out,
  output logic                  red_top_out,
  output logic                  green_top_out,
  output logic                  blue_top_out,
  output logic                  red_bot_out,
  output logic                  green_bot_out,
  output logic                  blue_bot_out,
  output logic                  bit_clk_out,
  output logic [ADDR_W-1:0]     address_out
);

  // Half bit-clock period in system cycles, never below one.
  localparam int HALF_RAW = SYS_CLK_FREQ / (2 * BCLK_FREQ);
  localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
  localparam int BIT_CYC  = 2 * HALF;
  localparam int PH_W     = $clog2(BIT_CYC);
  localparam int COL_W    = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(BIT_CYC - 1);
  localparam logic [PH_W-1:0]  HALF_M1  = PH_W'(HALF - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_LATCH = 2'd2;

  logic [1:0]            r_state;
  logic                  r_arm;
  logic                  r_ready;
  logic                  r_latch;
  logic                  r_bclk;
  logic [5:0]            r_pix;
  logic [ADDR_W-1:0]     r_addr_out;
  logic [ADDR_W-1:0]     r_addr_cap;
  logic [6*NUM_COLS-1:0] r_row;
  logic [PH_W-1:0]       r_phase;
  logic [COL_W-1:0]      r_col;

  logic [COL_W-1:0]      w_col_nxt;
  logic [5:0]            w_pix_first;
  logic [5:0]            w_pix_nxt;
  logic                  w_bit_end;
  logic                  w_last_col;

  assign w_col_nxt  = r_col + COL_W'(1);
  assign w_bit_end  = (r_phase == PH_LAST);
  assign w_last_col = (r_col == COL_LAST);

  // Column 0 comes straight from the input so it is on the pins the cycle
  // after accept; later columns come from the captured copy.
  always_comb begin
    w_pix_first = '0;
    w_pix_nxt   = '0;
    for (int k = 0; k < 6; k++) begin
      w_pix_first[k] = row_in[k*NUM_COLS];
      w_pix_nxt[k]   = r_row[k*NUM_COLS + int'(w_col_nxt)];
    end
  end

  always_ff @(posedge clk_in) begin
    if (!n_reset_in) begin
      r_state    <= S_IDLE;
      r_arm      <= 1'b0;
      r_ready    <= 1'b0;
      r_latch    <= 1'b0;
      r_bclk     <= 1'b0;
      r_pix      <= '0;
      r_addr_out <= '0;
      r_addr_cap <= '0;
      r_row      <= '0;
      r_phase    <= '0;
      r_col      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // r_arm delays the first ready after reset by one cycle.
          r_arm   <= 1'b1;
          r_latch <= 1'b0;
          r_bclk  <= 1'b0;
          r_pix   <= '0;
          if (r_ready && row_valid_in) begin
            r_row      <= row_in;
            r_addr_cap <= row_address_in;
            r_ready    <= 1'b0;
            r_pix      <= w_pix_first;
            r_phase    <= '0;
            r_col      <= '0;
            r_state    <= S_SHIFT;
          end else begin
            r_ready <= r_arm;
          end
        end

        S_SHIFT: begin
          if (w_bit_end) begin
            // End of a high phase: bit clock falls together with the data
            // change, so data only moves while the clock is low.
            r_phase <= '0;
            r_bclk  <= 1'b0;
            if (w_last_col) begin
              r_pix      <= '0;
              r_latch    <= 1'b1;
              r_addr_out <= r_addr_cap;
              r_state    <= S_LATCH;
            end else begin
              r_col <= w_col_nxt;
              r_pix <= w_pix_nxt;
            end
          end else begin
            r_phase <= r_phase + PH_W'(1);
            // Next phase index >= HALF means the high half of the bit.
            r_bclk  <= (r_phase >= HALF_M1);
          end
        end

        S_LATCH: begin
          if (w_bit_end) begin
            r_phase <= '0;
            r_latch <= 1'b0;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_phase <= r_phase + PH_W'(1);
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          r_latch <= 1'b0;
          r_bclk  <= 1'b0;
          r_pix   <= '0;
          r_phase <= '0;
        end
      endcase
    end
  end

  assign row_ready_out = r_ready;
  assign latch_out     = r_latch;
  assign bit_clk_out   = r_bclk;
  assign address_out   = r_addr_out;
  assign red_top_out   = r_pix[0];
  assign green_top_out = r_pix[1];
  assign blue_top_out  = r_pix[2];
  assign red_bot_out   = r_pix[3];
  assign green_bot_out = r_pix[4];
  assign blue_bot_out  = r_pix[5];

endmodule

// File: tb/tb_led_display_phy.sv
// tb_led_display_phy: randomized scenarios for led_display_phy against a
// pixel/latch reference built from the row layout and timing rules.
module tb_led_display_phy;
  localparam int NC = 64;
  localparam int AW = 4;
  localparam int RW = 6 * NC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          n_rst;
  logic [RW-1:0] row;
  logic          vld;
  logic [AW-1:0] addr;
  wire           rdy, latch, rt, gt, bt, rb, gb, bb, bclk;
  wire  [AW-1:0] aout;

  led_display_phy dut (
    .clk_in(clk), .n_reset_in(n_rst), .row_in(row), .row_valid_in(vld),
    .row_ready_out(rdy), .row_address_in(addr), .latch_out(latch),
    .red_top_out(rt), .green_top_out(gt), .blue_top_out(bt),
    .red_bot_out(rb), .green_bot_out(gb), .blue_bot_out(bb),
    .bit_clk_out(bclk), .address_out(aout)
  );

  int n_chk = 0;
  int n_pass = 0;

  // ---------------- observation ----------------
  int cyc = 0;
  int acc_cyc[$];
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (n_rst === 1'b1 && vld === 1'b1 && rdy === 1'b1) acc_cyc.push_back(cyc);
  end

  logic [5:0]    col_now, prev_col;
  logic          prev_bclk, prev_latch, prev_rdy;
  int            lat_len;
  logic [5:0]    rise_bits[$];
  int            rise_cyc[$];
  int            lat_start[$];
  int            lat_len_q[$];
  logic [AW-1:0] lat_addr[$];
  int            rdy_cyc[$];
  int            hi_change = 0;

  always @(negedge clk) begin
    col_now = {bb, gb, rb, bt, gt, rt};
    if (bclk === 1'b1 && prev_bclk !== 1'b1) begin
      rise_bits.push_back(col_now);
      rise_cyc.push_back(cyc);
    end
    if (bclk === 1'b1 && col_now !== prev_col) hi_change++;
    if (latch === 1'b1) begin
      if (prev_latch !== 1'b1) begin
        lat_start.push_back(cyc);
        lat_addr.push_back(aout);
        lat_len = 0;
      end
      lat_len++;
    end else if (prev_latch === 1'b1) begin
      lat_len_q.push_back(lat_len);
    end
    if (rdy === 1'b1 && prev_rdy !== 1'b1) rdy_cyc.push_back(cyc);
    prev_col   = col_now;
    prev_bclk  = bclk;
    prev_latch = latch;
    prev_rdy   = rdy;
  end

  // ---------------- reference model ----------------
  logic [RW-1:0] exp_row[$];
  logic [AW-1:0] exp_addr[$];

  // Colour lines for column c: slice k of the row, bit c.
  function automatic logic [5:0] px(input logic [RW-1:0] r, input int c);
    logic [5:0] p;
    for (int k = 0; k < 6; k++) p[k] = r[k*NC + c];
    return p;
  endfunction

  // Number of sampled bits that disagree with the expected rows, or 9999 if
  // the number of bit-clock rises is not 64 per row.
  function automatic int bit_errs();
    int e = 0;
    if (rise_bits.size() != NC * exp_row.size()) return 9999;
    foreach (exp_row[i])
      for (int c = 0; c < NC; c++)
        if (rise_bits[i*NC + c] !== px(exp_row[i], c)) e++;
    return e;
  endfunction

  function automatic logic [RW-1:0] rand_row();
    logic [RW-1:0] r;
    for (int w = 0; w < RW / 32; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [AW+8:0] all_outs();
    return {rdy, latch, rt, gt, bt, rb, gb, bb, bclk, aout};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    rise_bits.delete(); rise_cyc.delete(); lat_start.delete();
    lat_len_q.delete(); lat_addr.delete(); rdy_cyc.delete();
    acc_cyc.delete(); exp_row.delete(); exp_addr.delete();
    hi_change = 0;
  endtask

  task automatic do_accept(input logic [RW-1:0] r, input logic [AW-1:0] a, output bit ok);
    int n0;
    n0 = acc_cyc.size();
    ok = 1'b0;
    row = r; addr = a; vld = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (acc_cyc.size() > n0) begin ok = 1'b1; break; end
    end
    vld = 1'b0;
    if (ok) begin exp_row.push_back(r); exp_addr.push_back(a); end
  endtask

  task automatic wait_rdy(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (rdy === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_rst = 1'b0; vld = 1'b0; row = '0; addr = '0;
    repeat (10) tick();
    n_chk++;
    if (all_outs() !== '0) $display("FAIL reset_outs: got %h want 0", all_outs());
    else n_pass++;
    clear_mon();
    n_rst = 1'b1;
    tick();
    n_chk++;
    if (rdy !== 1'b0) $display("FAIL reset_rdy_first: got %b want 0", rdy);
    else n_pass++;
    tick();
    n_chk++;
    if (rdy !== 1'b1) $display("FAIL reset_rdy_second: got %b want 1", rdy);
    else n_pass++;
    repeat (5) tick();
    n_chk++;
    if (rise_bits.size() != 0 || bclk !== 1'b0)
      $display("FAIL reset_idle_bclk: got %0d rises bclk=%b want 0 rises bclk=0", rise_bits.size(), bclk);
    else n_pass++;
  endtask

  task automatic test_single_row();
    logic [RW-1:0] r;
    bit ok, ok2;
    int rt_ones, rt_idx, bb_ones, bb_idx, acc, d;
    clear_mon();
    r = '0;
    r[0*NC + 0]  = 1'b1;
    r[5*NC + 63] = 1'b1;
    do_accept(r, 4'h5, ok);
    wait_rdy(400, ok2);
    n_chk++;
    if (!(ok && ok2)) $display("FAIL single_handshake: got accept=%0d ready=%0d want 1 1", ok, ok2);
    else n_pass++;
    n_chk++;
    if (rise_bits.size() != NC) $display("FAIL single_rises: got %0d want %0d", rise_bits.size(), NC);
    else n_pass++;
    rt_ones = 0; rt_idx = -1; bb_ones = 0; bb_idx = -1;
    foreach (rise_bits[i]) begin
      if (rise_bits[i][0] === 1'b1) begin rt_ones++; rt_idx = i; end
      if (rise_bits[i][5] === 1'b1) begin bb_ones++; bb_idx = i; end
    end
    n_chk++;
    if (rt_ones != 1 || rt_idx != 0)
      $display("FAIL single_red_top: got %0d ones last at rise %0d want 1 at rise 0", rt_ones, rt_idx);
    else n_pass++;
    n_chk++;
    if (bb_ones != 1 || bb_idx != NC - 1)
      $display("FAIL single_blue_bot: got %0d ones last at rise %0d want 1 at rise %0d", bb_ones, bb_idx, NC - 1);
    else n_pass++;
    n_chk++;
    if (bit_errs() != 0) $display("FAIL single_bits: got %0d errors want 0", bit_errs());
    else n_pass++;
    n_chk++;
    if (aout !== 4'h5) $display("FAIL single_addr: got %h want 5", aout);
    else n_pass++;
    n_chk++;
    d = (lat_len_q.size() == 1) ? lat_len_q[0] : -1;
    if (d != 4) $display("FAIL single_latch_len: got %0d want 4", d);
    else n_pass++;
    acc = (acc_cyc.size() > 0) ? acc_cyc[0] : -1000;
    n_chk++;
    d = (rise_cyc.size() > 0) ? rise_cyc[0] - acc + 1 : -1;
    if (d != 3) $display("FAIL single_first_rise: got T+%0d want T+3", d);
    else n_pass++;
    n_chk++;
    d = (lat_start.size() > 0) ? lat_start[0] - acc + 1 : -1;
    if (d != 257) $display("FAIL single_latch_start: got T+%0d want T+257", d);
    else n_pass++;
    n_chk++;
    d = (rdy_cyc.size() > 0) ? rdy_cyc[rdy_cyc.size()-1] - acc + 1 : -1;
    if (d != 261) $display("FAIL single_ready_back: got T+%0d want T+261", d);
    else n_pass++;
  endtask

  task automatic test_pattern();
    logic [RW-1:0] r;
    logic [AW-1:0] a;
    bit ok, ok2;
    int alt_err;
    clear_mon();
    r = rand_row();
    r[1*NC +: NC] = 64'hAAAA_AAAA_AAAA_AAAA;
    a = AW'($urandom);
    do_accept(r, a, ok);
    wait_rdy(400, ok2);
    n_chk++;
    if (!(ok && ok2)) $display("FAIL pattern_handshake: got accept=%0d ready=%0d want 1 1", ok, ok2);
    else n_pass++;
    alt_err = (rise_bits.size() == NC) ? 0 : 9999;
    foreach (rise_bits[i]) if (rise_bits[i][1] !== 1'(i % 2)) alt_err++;
    n_chk++;
    if (alt_err != 0) $display("FAIL pattern_green_alt: got %0d errors want 0", alt_err);
    else n_pass++;
    n_chk++;
    if (bit_errs() != 0) $display("FAIL pattern_bits: got %0d errors want 0", bit_errs());
    else n_pass++;
    n_chk++;
    if (hi_change != 0) $display("FAIL pattern_stable_high: got %0d changes want 0", hi_change);
    else n_pass++;
    n_chk++;
    if (aout !== a) $display("FAIL pattern_addr: got %h want %h", aout, a);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [RW-1:0] rows[16];
    int nacc, gap_err, addr_err;
    bit ok;
    clear_mon();
    foreach (rows[i]) rows[i] = rand_row();
    nacc = 0;
    row = rows[0]; addr = '0; vld = 1'b1;
    for (int t = 0; t < 16 * 270; t++) begin
      tick();
      if (acc_cyc.size() > nacc) begin
        exp_row.push_back(rows[nacc]);
        exp_addr.push_back(AW'(nacc));
        nacc++;
        if (nacc == 16) break;
        row = rows[nacc]; addr = AW'(nacc);
      end
    end
    vld = 1'b0;
    wait_rdy(400, ok);
    n_chk++;
    if (acc_cyc.size() != 16 || !ok)
      $display("FAIL b2b_accepts: got %0d accepts ready=%0d want 16 ready=1", acc_cyc.size(), ok);
    else n_pass++;
    gap_err = 0;
    for (int i = 1; i < acc_cyc.size(); i++) if (acc_cyc[i] - acc_cyc[i-1] != 261) gap_err++;
    n_chk++;
    if (gap_err != 0) $display("FAIL b2b_accept_gap: got %0d gaps != 261 want 0", gap_err);
    else n_pass++;
    addr_err = (lat_addr.size() == 16) ? 0 : 9999;
    foreach (lat_addr[i]) if (lat_addr[i] !== exp_addr[i]) addr_err++;
    n_chk++;
    if (addr_err != 0) $display("FAIL b2b_latch_addr: got %0d errors over %0d latches want 0 over 16", addr_err, lat_addr.size());
    else n_pass++;
    n_chk++;
    if (bit_errs() != 0) $display("FAIL b2b_bits: got %0d errors want 0", bit_errs());
    else n_pass++;
    n_chk++;
    if (aout !== 4'hF) $display("FAIL b2b_final_addr: got %h want f", aout);
    else n_pass++;
  endtask

  task automatic test_valid_busy();
    logic [RW-1:0] r;
    logic [AW-1:0] a;
    bit ok, ok2;
    clear_mon();
    r = rand_row();
    a = AW'($urandom);
    do_accept(r, a, ok);
    for (int i = 0; i < 200; i++) begin
      vld  = 1'($urandom);
      row  = rand_row();
      addr = AW'($urandom);
      tick();
    end
    vld = 1'b0;
    wait_rdy(400, ok2);
    n_chk++;
    if (!ok || !ok2 || acc_cyc.size() != 1)
      $display("FAIL busy_accepts: got %0d accepts want 1", acc_cyc.size());
    else n_pass++;
    n_chk++;
    if (bit_errs() != 0) $display("FAIL busy_bits: got %0d errors want 0", bit_errs());
    else n_pass++;
    n_chk++;
    if (lat_start.size() != 1 || aout !== a)
      $display("FAIL busy_latch: got %0d latches addr %h want 1 addr %h", lat_start.size(), aout, a);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    logic [RW-1:0] r;
    logic [AW-1:0] a;
    bit ok, ok2;
    int acc;
    clear_mon();
    r = rand_row();
    do_accept(r, 4'h9, ok);
    acc = (acc_cyc.size() > 0) ? acc_cyc[0] : cyc;
    for (int i = 0; i < 200 && cyc < acc + 99; i++) tick();
    n_rst = 1'b0;
    tick();
    n_chk++;
    if (!ok || all_outs() !== '0) $display("FAIL midrst_outs: got %h want 0", all_outs());
    else n_pass++;
    repeat (3) tick();
    n_rst = 1'b1;
    repeat (6) tick();
    n_chk++;
    if (lat_start.size() != 0) $display("FAIL midrst_no_latch: got %0d latches want 0", lat_start.size());
    else n_pass++;
    clear_mon();
    r = rand_row();
    a = AW'($urandom);
    do_accept(r, a, ok);
    wait_rdy(400, ok2);
    n_chk++;
    if (!(ok && ok2) || bit_errs() != 0)
      $display("FAIL midrst_next_row: got accept=%0d ready=%0d errors=%0d want 1 1 0", ok, ok2, bit_errs());
    else n_pass++;
    n_chk++;
    if (lat_start.size() != 1 || aout !== a)
      $display("FAIL midrst_next_latch: got %0d latches addr %h want 1 addr %h", lat_start.size(), aout, a);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_pattern();
    test_back_to_back();
    test_valid_busy();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
